// File: rtl/crc_tx_pkg.sv
// Shared types and constants for the CRC-16 transmit frame controller.
// State encoding, output-buffer load selector, engine init value and engine latency.
package crc_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        FEED,
        WAIT,
        NEXT,
        CRC_HI,
        CRC_LO
    } state_e;

    typedef enum logic [1:0] {
        LOAD_NONE,
        LOAD_DATA,
        LOAD_CRC_HI,
        LOAD_CRC_LO
    } obuf_load_e;

    localparam logic [15:0] CRC_INIT       = 16'hFFFF;
    localparam int          CRC_ENGINE_LAT = 7;

endpackage

// File: rtl/crc_tx_frame_obuf.sv
// One-entry downstream holding register with sop/eop sideband.
// A load picks the data byte or one half of the CRC; otherwise the entry drains on handshake.
module crc_tx_frame_obuf
    import crc_tx_pkg::*;
(
    input  logic        clk,
    input  logic        sclr,
    input  obuf_load_e  i_load,
    input  logic [7:0]  i_byte,
    input  logic        i_sop,
    input  logic [15:0] i_crc,
    input  logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    output logic        o_sop,
    output logic        o_eop
);

    logic [7:0] r_data;
    logic       r_valid;
    logic       r_sop;
    logic       r_eop;

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
        end else begin
            case (i_load)
                LOAD_DATA: begin
                    r_data  <= i_byte;
                    r_valid <= 1'b1;
                    r_sop   <= i_sop;
                    r_eop   <= 1'b0;
                end
                LOAD_CRC_HI: begin
                    r_data  <= i_crc[15:8];
                    r_valid <= 1'b1;
                    r_sop   <= 1'b0;
                    r_eop   <= 1'b0;
                end
                LOAD_CRC_LO: begin
                    r_data  <= i_crc[7:0];
                    r_valid <= 1'b1;
                    r_sop   <= 1'b0;
                    r_eop   <= 1'b1;
                end
                default: begin
                    if (r_valid && i_ready) begin
                        r_valid <= 1'b0;
                        r_sop   <= 1'b0;
                        r_eop   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_sop   = r_sop;
    assign o_eop   = r_eop;

endmodule

// File: rtl/crc_tx_frame_ctrl.sv
// Frame sequencer feeding an external byte-serial CRC-16 engine and appending the CRC bytes.
// Optional framing checks enabled by defining CRC_TX_PROTO_CHK_EN.
module crc_tx_frame_ctrl
    import crc_tx_pkg::*;
(
    input  logic        clk,
    input  logic        sclr,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_sop,
    input  logic        s_eop,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_sop,
    output logic        m_eop,
    input  logic        m_ready,
    output logic        crc_sclr,
    output logic [7:0]  crc_data,
    output logic        crc_en,
    input  logic [15:0] crc_result,
    input  logic        crc_ok,
    output logic        err_proto
);

    state_e      r_state;
    logic [7:0]  r_byte;
    logic        r_eop;
    logic        r_okSeen;
    logic        r_outDone;
    logic [15:0] r_crc;

    logic        w_accept;
    logic        w_mValid;
    logic        w_mFire;
    logic        w_waitDone;
    logic [15:0] w_crcNow;
    obuf_load_e  w_load;
    logic [7:0]  w_loadByte;
    logic        w_loadSop;

    assign s_ready    = ((r_state == IDLE) || (r_state == NEXT)) && !sclr;
    assign w_accept   = s_valid && s_ready;
    assign w_mFire    = w_mValid && m_ready;
    assign w_waitDone = (r_okSeen || crc_ok) && (r_outDone || w_mFire);
    assign w_crcNow   = ((r_state == WAIT) && crc_ok) ? crc_result : r_crc;
    assign crc_sclr   = sclr || (r_state == CLR);
    assign crc_en     = (r_state == FEED);
    assign crc_data   = r_byte;
    assign m_valid    = w_mValid;

    // The output buffer is loaded on the edge that enters FEED / CRC_HI / CRC_LO,
    // so the byte is presented in the same cycle the state is entered.
    always_comb begin
        w_load     = LOAD_NONE;
        w_loadByte = r_byte;
        w_loadSop  = 1'b0;
        case (r_state)
            CLR: begin
                w_load    = LOAD_DATA;
                w_loadSop = 1'b1;
            end
            NEXT: begin
                if (w_accept) begin
                    w_load     = LOAD_DATA;
                    w_loadByte = s_data;
                end
            end
            WAIT: begin
                if (w_waitDone && r_eop) w_load = LOAD_CRC_HI;
            end
            CRC_HI: begin
                if (w_mFire) w_load = LOAD_CRC_LO;
            end
            default: ;
        endcase
    end

`ifdef CRC_TX_PROTO_CHK_EN
    logic r_errProto;
    assign err_proto = r_errProto;
`else
    logic w_unusedSop;
    assign w_unusedSop = s_sop;
    assign err_proto   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (sclr) begin
            r_state   <= IDLE;
            r_byte    <= 8'h00;
            r_eop     <= 1'b0;
            r_okSeen  <= 1'b0;
            r_outDone <= 1'b0;
            r_crc     <= CRC_INIT;
`ifdef CRC_TX_PROTO_CHK_EN
            r_errProto <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
`ifdef CRC_TX_PROTO_CHK_EN
                    if (w_accept && !s_sop) begin
                        r_errProto <= 1'b1;
                    end else if (w_accept) begin
                        r_byte  <= s_data;
                        r_eop   <= s_eop;
                        r_state <= CLR;
                    end
`else
                    if (w_accept) begin
                        r_byte  <= s_data;
                        r_eop   <= s_eop;
                        r_state <= CLR;
                    end
`endif
                end
                CLR: begin
                    r_okSeen  <= 1'b0;
                    r_outDone <= 1'b0;
                    r_state   <= FEED;
                end
                FEED: begin
                    r_outDone <= w_mFire;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (crc_ok) begin
                        r_okSeen <= 1'b1;
                        r_crc    <= crc_result;
                    end
                    if (w_mFire) r_outDone <= 1'b1;
                    if (w_waitDone) begin
                        r_okSeen  <= 1'b0;
                        r_outDone <= 1'b0;
                        r_state   <= r_eop ? CRC_HI : NEXT;
                    end
                end
                NEXT: begin
                    if (w_accept) begin
                        r_byte  <= s_data;
                        r_eop   <= s_eop;
                        r_state <= FEED;
`ifdef CRC_TX_PROTO_CHK_EN
                        if (s_sop) r_errProto <= 1'b1;
`endif
                    end
                end
                CRC_HI: begin
                    if (w_mFire) r_state <= CRC_LO;
                end
                CRC_LO: begin
                    if (w_mFire) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    crc_tx_frame_obuf u_obuf (
        .clk     (clk),
        .sclr    (sclr),
        .i_load  (w_load),
        .i_byte  (w_loadByte),
        .i_sop   (w_loadSop),
        .i_crc   (w_crcNow),
        .i_ready (m_ready),
        .o_data  (m_data),
        .o_valid (w_mValid),
        .o_sop   (m_sop),
        .o_eop   (m_eop)
    );

endmodule

// File: tb/tb_crc_tx_frame_ctrl.sv
// Bench for crc_tx_frame_ctrl: models the CRC engine beside the DUT and checks the output stream
// against a frame-level model (data bytes followed by the CRC-16 of the frame, high byte first).
module tb_crc_tx_frame_ctrl;
    import crc_tx_pkg::*;

    logic        clk = 1'b0;
    logic        sclr = 1'b1;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_sop = 1'b0;
    logic        s_eop = 1'b0;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_sop;
    logic        m_eop;
    logic        m_ready = 1'b1;
    logic        crc_sclr;
    logic [7:0]  crc_data;
    logic        crc_en;
    logic [15:0] crc_result = CRC_INIT;
    logic        crc_ok = 1'b0;
    logic        err_proto;

    int          nVec = 0;
    int          nFail = 0;
    int          cycle = 0;
    int          sclrPulses = 0;
    bit          rdyRandom = 1'b0;
    logic [9:0]  expQ[$];
    logic [7:0]  frameBuf[$];
    int          acceptCyc[$];
    logic [15:0] engCrc = CRC_INIT;
    int          engCnt = 0;
    bit          stallPrev = 1'b0;
    logic [10:0] stallSnap = '0;

    crc_tx_frame_ctrl dut (
        .clk        (clk),
        .sclr       (sclr),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_sop      (s_sop),
        .s_eop      (s_eop),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_sop      (m_sop),
        .m_eop      (m_eop),
        .m_ready    (m_ready),
        .crc_sclr   (crc_sclr),
        .crc_data   (crc_data),
        .crc_en     (crc_en),
        .crc_result (crc_result),
        .crc_ok     (crc_ok),
        .err_proto  (err_proto)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [15:0] crcStep(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {d, 8'h00};
        for (int b = 0; b < 8; b++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
        return x;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Engine stand-in: cleared by crc_sclr, answers each crc_en with crc_ok after the fixed latency.
    always @(posedge clk) begin
        if (crc_sclr) begin
            engCrc     <= CRC_INIT;
            engCnt     <= 0;
            crc_ok     <= 1'b0;
            crc_result <= CRC_INIT;
        end else begin
            crc_ok <= 1'b0;
            if (crc_en) begin
                checkOutput("crcEnWhileBusy", engCnt, 0);
                engCrc <= crcStep(engCrc, crc_data);
                engCnt <= CRC_ENGINE_LAT - 1;
            end else if (engCnt > 0) begin
                engCnt <= engCnt - 1;
                if (engCnt == 1) begin
                    crc_ok     <= 1'b1;
                    crc_result <= engCrc;
                end
            end
        end
    end

    // Downstream sink: random or constant ready, compares every handshake and stall hold.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rdyRandom ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!sclr) begin
            if (crc_sclr) sclrPulses++;
            if (stallPrev) checkOutput("stallHold", {m_valid, m_sop, m_eop, m_data}, stallSnap);
            if (m_valid && m_ready) begin
                checkOutput("outPending", (expQ.size() != 0), 1);
                if (expQ.size() != 0) checkOutput("outByte", {m_sop, m_eop, m_data}, expQ.pop_front());
            end
            stallPrev = m_valid && !m_ready;
            stallSnap = {1'b1, m_sop, m_eop, m_data};
        end else begin
            stallPrev = 1'b0;
        end
    end

    task automatic applyStimulus(input int gapMax, input int nSend, input bit firstSop);
        logic [15:0] c;
        int          budget;
        bit          got;
        c = CRC_INIT;
        for (int i = 0; i < frameBuf.size(); i++) begin
            expQ.push_back({(i == 0), 1'b0, frameBuf[i]});
            c = crcStep(c, frameBuf[i]);
        end
        expQ.push_back({2'b00, c[15:8]});
        expQ.push_back({2'b01, c[7:0]});
        acceptCyc.delete();
        for (int i = 0; i < nSend; i++) begin
            repeat ($urandom_range(0, gapMax)) begin
                @(posedge clk);
                #1;
            end
            s_valid = 1'b1;
            s_data  = frameBuf[i];
            s_sop   = firstSop && (i == 0);
            s_eop   = (i == frameBuf.size() - 1);
            got     = 1'b0;
            budget  = 0;
            while (!got && budget < 300) begin
                @(negedge clk);
                got = s_ready;
                @(posedge clk);
                #1;
                budget++;
            end
            checkOutput("acceptInBudget", got, 1);
            if (got) acceptCyc.push_back(cycle);
            s_valid = 1'b0;
            s_sop   = 1'b0;
            s_eop   = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int budget;
        budget = 0;
        while (expQ.size() != 0 && budget < 3000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        checkOutput("drainInBudget", expQ.size(), 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic loadDigits();
        frameBuf.delete();
        for (int i = 0; i < 9; i++) frameBuf.push_back(8'h31 + 8'(i));
    endtask

    task automatic resetDut();
        sclr = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rstReady", s_ready, 0);
        checkOutput("rstFlags", {m_valid, m_sop, m_eop, crc_en, err_proto, crc_sclr}, 6'b000001);
        checkOutput("rstData", {m_data, crc_data}, 16'h0000);
        checkOutput("rstCrc", dut.r_crc, 16'hFFFF);
        sclr = 1'b0;
        expQ.delete();
        @(posedge clk);
        #1;
        checkOutput("rstReadyAfter", s_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int mvSeen;
        bit got;
        int budget;

        rdyRandom = 1'b0;
        resetDut();

        // Single byte 0x00: cycle-accurate handshake with the engine and CRC append.
        frameBuf.delete();
        frameBuf.push_back(8'h00);
        expQ.push_back({2'b10, 8'h00});
        expQ.push_back({2'b00, 8'hE1});
        expQ.push_back({2'b01, 8'hF0});
        s_valid = 1'b1; s_data = 8'h00; s_sop = 1'b1; s_eop = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
        checkOutput("clrCycle", {crc_sclr, crc_en, s_ready, m_valid}, 4'b1000);
        @(posedge clk); #1;
        checkOutput("feedCycle", {crc_en, crc_data, m_valid, m_sop, m_data}, {1'b1, 8'h00, 1'b1, 1'b1, 8'h00});
        repeat (7) begin @(posedge clk); #1; end
        checkOutput("waitOkCycle", {s_ready, m_valid, crc_en}, 3'b000);
        @(posedge clk); #1;
        checkOutput("crcHiCycle", {m_valid, m_eop, m_data}, {1'b1, 1'b0, 8'hE1});
        @(posedge clk); #1;
        checkOutput("crcLoCycle", {m_valid, m_eop, m_data}, {1'b1, 1'b1, 8'hF0});
        @(posedge clk); #1;
        checkOutput("idleAfterFrame", {s_ready, m_valid}, 2'b10);
        waitDrain();

        // "123456789", downstream always ready, no upstream gaps.
        loadDigits();
        sclrPulses = 0;
        applyStimulus(0, 9, 1'b1);
        waitDrain();
        checkOutput("sclrPulseCount", sclrPulses, 1);
        checkOutput("firstByteSpacing", acceptCyc[1] - acceptCyc[0], 10);
        checkOutput("steadySpacing", acceptCyc[5] - acceptCyc[4], 9);

        // Same frame with random backpressure and upstream gaps.
        rdyRandom = 1'b1;
        loadDigits();
        applyStimulus(3, 9, 1'b1);
        waitDrain();

        // Back-to-back frames: engine must be re-cleared for the second.
        rdyRandom = 1'b0;
        loadDigits();
        applyStimulus(0, 9, 1'b1);
        frameBuf.delete();
        frameBuf.push_back(8'h00);
        applyStimulus(0, 1, 1'b1);
        waitDrain();

        // Reset during WAIT of byte 4, then a full frame.
        loadDigits();
        applyStimulus(0, 4, 1'b1);
        @(posedge clk); #1;
        sclr = 1'b1;
        #1;
        checkOutput("midSclrReady", {s_ready, crc_sclr}, 2'b01);
        @(posedge clk); #1;
        checkOutput("midSclrOut", {m_valid, crc_en}, 2'b00);
        checkOutput("midSclrCrc", dut.r_crc, 16'hFFFF);
        sclr = 1'b0;
        expQ.delete();
        @(posedge clk); #1;
        checkOutput("midSclrIdle", s_ready, 1);
        loadDigits();
        applyStimulus(0, 9, 1'b1);
        waitDrain();

`ifdef CRC_TX_PROTO_CHK_EN
        // Byte without sop in IDLE is dropped and flags the error.
        s_valid = 1'b1; s_data = 8'h55; s_sop = 1'b0; s_eop = 1'b1;
        got = 1'b0; budget = 0;
        while (!got && budget < 50) begin
            @(negedge clk); got = s_ready; @(posedge clk); #1; budget++;
        end
        s_valid = 1'b0; s_eop = 1'b0;
        checkOutput("protoAccept", got, 1);
        mvSeen = 0;
        repeat (12) begin @(negedge clk); if (m_valid || crc_sclr) mvSeen++; end
        @(posedge clk); #1;
        checkOutput("protoNoOutput", mvSeen, 0);
        checkOutput("protoErrSet", {err_proto, s_ready}, 2'b11);
        loadDigits();
        applyStimulus(0, 9, 1'b1);
        waitDrain();
        checkOutput("protoErrSticky", err_proto, 1);
`else
        // Without checking, a byte lacking sop in IDLE still starts a frame.
        mvSeen = 0; got = 1'b0; budget = 0;
        frameBuf.delete();
        frameBuf.push_back(8'h55);
        applyStimulus(0, 1, 1'b0);
        waitDrain();
        checkOutput("errProtoTied", err_proto, 0);
`endif

        // Random frames under random backpressure.
        rdyRandom = 1'b1;
        for (int f = 0; f < 5; f++) begin
            frameBuf.delete();
            for (int i = 0; i < int'($urandom_range(1, 5)); i++) frameBuf.push_back(8'($urandom_range(0, 255)));
            applyStimulus(2, frameBuf.size(), 1'b1);
        end
        waitDrain();
        rdyRandom = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/crc_tx_frame_ctrl.md
# crc_tx_frame_ctrl

Frame-level sequencer for the optic transmitter's byte-serial CRC-16 engine (polynomial 1+x^5+x^12+x^16, init 0xFFFF, MSB-first, no reflection). It accepts a framed byte stream, clears the engine at start of frame, and feeds each byte with one `crc_en` pulse. It waits for the engine's `data_ok` pulse, forwards the bytes downstream, and appends the two CRC bytes after the last data byte. It sits between the TX framer and the serializer and owns the CRC engine exclusively.

## Interface
- No parameters; widths are fixed (8-bit data, 16-bit CRC).
- `clk` in 1: single clock for the block and the engine.
- `sclr` in 1: synchronous, active-high reset.
- `s_data` in 8: upstream byte.
- `s_valid` in 1: upstream byte valid.
- `s_sop` in 1: first byte of frame.
- `s_eop` in 1: last byte of frame.
- `s_ready` out 1: byte accepted on `s_valid & s_ready`.
- `m_data` out 8: downstream byte.
- `m_valid` out 1: downstream valid.
- `m_sop` out 1: first byte of frame.
- `m_eop` out 1: marks the CRC low byte.
- `m_ready` in 1: downstream accept.
- `crc_sclr` out 1: engine clear.
- `crc_data` out 8: engine byte.
- `crc_en` out 1: engine start pulse.
- `crc_result` in 16: engine `data_out`.
- `crc_ok` in 1: engine `data_ok`, a 1-cycle pulse.
- `err_proto` out 1: sticky framing error.

## Operation
- States:
  - IDLE: `s_ready` = 1. On accept, latch byte and eop flag, go to CLR.
  - CLR: `crc_sclr` = 1 for one cycle, go to FEED.
  - FEED: `crc_en` = 1 and `crc_data` = latched byte for one cycle. Load the output register with the byte (`m_sop` set for the first byte). Go to WAIT.
  - WAIT: two flags are set independently. `ok_seen` is set on `crc_ok`, which also captures `crc_result`. `out_done` is set on `m_valid & m_ready`. When both are set: go to CRC_HI if the byte was eop, else to NEXT.
  - NEXT: `s_ready` = 1. On accept, latch byte and go to FEED (no clear).
  - CRC_HI: `m_data` = crc[15:8]. On `m_ready`, go to CRC_LO.
  - CRC_LO: `m_data` = crc[7:0] with `m_eop` = 1. On `m_ready`, go to IDLE.
- `crc_sclr` = `sclr` OR (state == CLR). The engine is therefore also cleared during block reset.
- `crc_ok` outside WAIT is ignored. `m_data`/`m_sop`/`m_eop` hold while `m_valid & !m_ready`.
- `s_ready` is 0 in all states other than IDLE and NEXT. No byte is ever lost under backpressure.
- A frame with a single byte (`s_sop` & `s_eop`) yields 3 output bytes: the data byte, CRC high, CRC low.
- `sclr` mid-frame: the state returns to IDLE next cycle and all flags clear. The partial frame is abandoned with no trailing CRC.

## Timing
- Reset values:
  - `s_ready` = 0 during `sclr`, 1 in the first cycle after.
  - `m_valid`, `m_sop`, `m_eop`, `crc_en`, `err_proto` = 0.
  - `m_data` = 0x00, `crc_data` = 0x00, captured CRC = 0xFFFF.
- All outputs except `crc_sclr` are registered/state-decoded. There is no combinational path from `m_ready` or `s_valid` to any output.
- Engine contract: `crc_en` at cycle t gives `crc_ok` at t+7. The engine accepts its next `crc_en` at t+7 or later. The controller's earliest next `crc_en` is t+9.
- First byte: accepted at cycle 0, `crc_sclr` at 1, `crc_en` and `m_valid` at 2, `crc_ok` at 9, `s_ready` at 10.
- Later bytes: accepted at n, `crc_en` at n+1, `s_ready` again at n+9 when downstream does not stall. Steady throughput is 1 byte per 9 cycles.
- After the eop byte completes: CRC_HI is valid in the next cycle, and CRC_LO follows one cycle after the CRC_HI handshake.

## Configuration
- `CRC_TX_PROTO_CHK_EN` defined:
  - A byte without `s_sop` in IDLE is accepted and discarded, and sets `err_proto`.
  - A byte with `s_sop` in NEXT sets `err_proto` and is processed as a continuation byte.
  - `err_proto` clears only on `sclr`.
- Not defined:
  - Any byte accepted in IDLE starts a frame, and `s_sop` is ignored elsewhere.
  - `err_proto` is tied to 0.

## Structure
- Shared package `crc_tx_pkg`:
  - state encoding typedef (IDLE, CLR, FEED, WAIT, NEXT, CRC_HI, CRC_LO);
  - `CRC_INIT` = 16'hFFFF;
  - `CRC_ENGINE_LAT` = 7.
- One natural sub-module: `crc_tx_frame_obuf`, a one-entry output holding register with valid/ready and sop/eop sideband, muxed between the data byte and the CRC bytes.
- The `crc_tx` engine is instantiated beside the controller, not inside it.

## Test plan
- Frame "123456789" (0x31..0x39, sop on 0x31, eop on 0x39), `m_ready` held 1 -> output bytes 0x31..0x39, 0x29, 0xB1. `m_sop` on 0x31, `m_eop` on 0xB1. `crc_sclr` pulses exactly once.
- Single-byte frame 0x00 with sop & eop -> output 0x00, 0xE1, 0xF0. The spacing from `crc_en` to `crc_ok` is exactly 7 cycles.
- Same "123456789" frame with `m_ready` toggled pseudo-randomly -> identical output sequence, with no duplicate or dropped bytes and `m_data` stable while stalled.
- Two back-to-back frames, 0x31..0x39 then 0x00 -> the second CRC is 0xE1F0, proving the engine is re-cleared at every sop.
- `sclr` asserted in WAIT of byte 4 -> next cycle: IDLE, `m_valid` = 0, captured CRC = 0xFFFF. A following full frame yields 0x29B1.
- With `CRC_TX_PROTO_CHK_EN`: byte 0x55 without sop in IDLE -> dropped, no `m_valid`, `err_proto` = 1 and it stays 1 through the next valid frame.
